// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared widths, fetch FSM states and reset PC for the fetch stage
package pc_fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and req/ack instruction fetch with valid/stall output (optional PC_ALIGN_CHECK_EN)
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               branch_taken_i,
    input  logic [31:0]        jump_address_i,
    input  logic               stall_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [PC_W-1:0]    pc_plus_two_o,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    output logic               misalign_err_o
);

    fetch_state_t        state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     addr_q, addr_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                req_q, req_d;
    logic [PC_W-1:0]     target;
    logic                unused_jump_bits;

    // Instructions are halfword aligned, so bit 0 of the target is always dropped
    assign target           = {jump_address_i[15:1], 1'b0};
    assign unused_jump_bits = &{1'b0, jump_address_i[31:16], jump_address_i[0]};

    assign pc_o           = pc_q;
    assign pc_plus_two_o  = pc_q + 16'd2;
    assign imem_req_o     = req_q;
    assign imem_addr_o    = addr_q;
    assign instr_o        = instr_q;
    assign instr_valid_o  = (state_q == VALID);

    // Next-state, PC, fetch address and captured instruction
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE: begin
                state_d = WAIT;
                pc_d    = branch_taken_i ? target : pc_q;
                addr_d  = pc_d;
            end
            WAIT: begin
                if (branch_taken_i && imem_ack_i) begin
                    pc_d   = target;
                    addr_d = target;
                end else if (branch_taken_i) begin
                    pc_d    = target;
                    state_d = DRAIN;
                end else if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    state_d = VALID;
                end
            end
            DRAIN: begin
                pc_d = branch_taken_i ? target : pc_q;
                if (imem_ack_i) begin
                    addr_d  = pc_d;
                    state_d = WAIT;
                end
            end
            VALID: begin
                if (branch_taken_i || !stall_i) begin
                    pc_d    = branch_taken_i ? target : pc_plus_two_o;
                    addr_d  = pc_d;
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == WAIT) || (state_d == DRAIN);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            req_q   <= req_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    // Sticky flag for any taken branch to an odd target
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else if (branch_taken_i && jump_address_i[0]) misalign_q <= 1'b1;
    end

    assign misalign_err_o = misalign_q;
`else
    assign misalign_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] jump_address = '0;
    logic        stall = 1'b0;
    logic [15:0] pc, pc_plus_two, imem_addr, imem_rdata, instr;
    logic        imem_req, imem_ack, instr_valid, misalign_err;
    logic        ack_block = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic        exp_mis;

    pc_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .branch_taken_i (branch_taken),
        .jump_address_i (jump_address),
        .stall_i        (stall),
        .pc_o           (pc),
        .pc_plus_two_o  (pc_plus_two),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ack_i     (imem_ack),
        .imem_rdata_i   (imem_rdata),
        .instr_o        (instr),
        .instr_valid_o  (instr_valid),
        .misalign_err_o (misalign_err)
    );

    always #5 clk = ~clk;

    // Memory model: zero-wait unless blocked, data = A000 + address
    always_comb begin
        imem_ack   = imem_req && !ack_block;
        imem_rdata = 16'hA000 + imem_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        total++; if (instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h exp=0000", instr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", misalign_err); end
        total++; if (pc_plus_two !== 16'h0002) begin bad++; $display("FAIL reset_pc2 got=%h exp=0002", pc_plus_two); end
        rst = 1'b0;
        step();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rel_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL rel_addr got=%h exp=0000", imem_addr); end
    endtask

    task automatic test_sequential();
        logic [15:0] ep;
        step();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                step();
                total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL seq_gap%0d valid=%b req=%b exp valid=0 req=1", i, instr_valid, imem_req); end
                step();
            end
            ep = 16'(2 * i);
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d got=%b exp=1", i, instr_valid); end
            total++; if (pc !== ep) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, ep); end
            total++; if (instr !== 16'hA000 + ep) begin bad++; $display("FAIL seq_instr%0d got=%h exp=%h", i, instr, 16'hA000 + ep); end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (instr_valid !== 1'b1 || pc !== 16'h0004 || instr !== 16'hA004 || imem_req !== 1'b0) begin
                bad++; $display("FAIL stall%0d valid=%b pc=%h instr=%h req=%b exp 1/0004/A004/0", i, instr_valid, pc, instr, imem_req);
            end
        end
    endtask

    task automatic test_branch_valid();
        branch_taken = 1'b1;
        jump_address = 32'h0000_0100;
        step();
        branch_taken = 1'b0;
        stall = 1'b0;
        total++; if (imem_addr !== 16'h0100 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL brv_wait addr=%h req=%b valid=%b exp 0100/1/0", imem_addr, imem_req, instr_valid);
        end
        step();
        total++; if (instr_valid !== 1'b1 || pc !== 16'h0100 || instr !== 16'hA100) begin
            bad++; $display("FAIL brv_present valid=%b pc=%h instr=%h exp 1/0100/A100", instr_valid, pc, instr);
        end
    endtask

    task automatic test_branch_wait();
        ack_block = 1'b1;
        branch_taken = 1'b1;
        jump_address = 32'h0000_0006;
        step();
        branch_taken = 1'b0;
        total++; if (imem_addr !== 16'h0006 || imem_req !== 1'b1) begin bad++; $display("FAIL brw_addr6 addr=%h req=%b exp 0006/1", imem_addr, imem_req); end
        step();
        branch_taken = 1'b1;
        jump_address = 32'h0000_0200;
        step();
        branch_taken = 1'b0;
        total++; if (imem_addr !== 16'h0006 || pc !== 16'h0200 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL brw_drain addr=%h pc=%h req=%b valid=%b exp 0006/0200/1/0", imem_addr, pc, imem_req, instr_valid);
        end
        step();
        ack_block = 1'b0;
        step();
        total++; if (imem_addr !== 16'h0200 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL brw_refetch addr=%h req=%b valid=%b exp 0200/1/0", imem_addr, imem_req, instr_valid);
        end
        step();
        total++; if (instr_valid !== 1'b1 || pc !== 16'h0200 || instr !== 16'hA200) begin
            bad++; $display("FAIL brw_present valid=%b pc=%h instr=%h exp 1/0200/A200", instr_valid, pc, instr);
        end
    endtask

    task automatic test_branch_ack();
        step();
        branch_taken = 1'b1;
        jump_address = 32'h0000_0300;
        step();
        branch_taken = 1'b0;
        total++; if (imem_addr !== 16'h0300 || pc !== 16'h0300 || instr_valid !== 1'b0 || instr !== 16'hA200) begin
            bad++; $display("FAIL bra_same addr=%h pc=%h valid=%b instr=%h exp 0300/0300/0/A200", imem_addr, pc, instr_valid, instr);
        end
        step();
        total++; if (instr_valid !== 1'b1 || pc !== 16'h0300 || instr !== 16'hA300) begin
            bad++; $display("FAIL bra_present valid=%b pc=%h instr=%h exp 1/0300/A300", instr_valid, pc, instr);
        end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1;
        jump_address = 32'h0000_FFFE;
        step();
        branch_taken = 1'b0;
        step();
        total++; if (pc !== 16'hFFFE || instr !== 16'h9FFE || pc_plus_two !== 16'h0000) begin
            bad++; $display("FAIL wrap_top pc=%h instr=%h pc2=%h exp FFFE/9FFE/0000", pc, instr, pc_plus_two);
        end
        step();
        total++; if (pc !== 16'h0000 || imem_addr !== 16'h0000 || pc_plus_two !== 16'h0002) begin
            bad++; $display("FAIL wrap_next pc=%h addr=%h pc2=%h exp 0000/0000/0002", pc, imem_addr, pc_plus_two);
        end
    endtask

    task automatic test_misalign();
`ifdef PC_ALIGN_CHECK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        step();
        branch_taken = 1'b1;
        jump_address = 32'hFFFF_0101;
        step();
        branch_taken = 1'b0;
        total++; if (pc !== 16'h0100 || imem_addr !== 16'h0100) begin bad++; $display("FAIL mis_target pc=%h addr=%h exp 0100/0100", pc, imem_addr); end
        total++; if (misalign_err !== exp_mis) begin bad++; $display("FAIL mis_flag got=%b exp=%b", misalign_err, exp_mis); end
        step();
        step();
        total++; if (misalign_err !== exp_mis || instr !== 16'hA100) begin bad++; $display("FAIL mis_sticky flag=%b instr=%h exp %b/A100", misalign_err, instr, exp_mis); end
    endtask

    task automatic test_reset_mid();
        step();
        ack_block = 1'b1;
        step();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL mid_pre req=%b exp 1", imem_req); end
        rst = 1'b1;
        step();
        ack_block = 1'b0;
        total++; if (imem_req !== 1'b0 || pc !== 16'h0000 || instr_valid !== 1'b0 || instr !== 16'h0000 || misalign_err !== 1'b0) begin
            bad++; $display("FAIL mid_rst req=%b pc=%h valid=%b instr=%h mis=%b exp 0/0000/0/0000/0", imem_req, pc, instr_valid, instr, misalign_err);
        end
        step();
        total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL mid_hold req=%b valid=%b exp 0/0", imem_req, instr_valid); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_valid();
        test_branch_wait();
        test_branch_ack();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
